alu_lfsr_sequencer: RTL and testbench
=====================================

# alu_lfsr_sequencer

Parametrised successor to the lab's step-driven LFSR/ALU control unit. Each iteration generates operands A and B from two W-bit LFSRs and opens an operation-select window while B is shown. It then computes one of eight ALU operations and presents every phase to the display path with a start pulse. Results are kept in a circular history buffer that the user browses in register mode. The block sits between the debounced switch/button logic and the 7-segment display driver, in the 10 MHz domain.

## Interface
- W, 8: operand width; supported values 4, 8, 16.
- DEPTH, 8: history entries; power of two, 2..32.
- DISP_CYC, 16: cycles each display phase is held; ≥1.
- OP_TIMEOUT, 0: cycles allowed in the op window; 0 means wait forever.
- SEED_A, 'h01 / SEED_B, 'h80: LFSR seeds; a zero seed is coerced to 1.
- clk  in  1  system clock; one clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- step_i  in  1  debounced single-cycle pulse; starts an iteration.
- op_valid_i  in  1  operation select strobe.
- op_i  in  3  operation code.
- hist_mode_i  in  1  register (history browse) mode level.
- hist_next_i  in  1  pulse; steps to the next-older history entry.
- disp_start_o  out  1  one-cycle pulse at the first cycle of each display phase.
- disp_val_o  out  2W  value to display.
- disp_src_o  out  2  display source: 0=A, 1=B, 2=ALU, 3=HIST.
- a_o, b_o  out  W  latched operands.
- result_o  out  2W  latched ALU result.
- carry_o, zero_o  out  1  flags of the last ALU operation.
- hist_count_o  out  $clog2(DEPTH+1)  number of valid history entries.
- busy_o  out  1  high in every state except S_WAIT and S_HIST.

## Operation
- States and transitions:
  - S_WAIT: if hist_mode_i → S_HIST; else if step_i → S_LFSRA. When both arrive in the same cycle, hist wins.
  - S_LFSRA: 1 cycle; advance LFSR A; a_o ← new value → S_SHOWA.
  - S_SHOWA: held DISP_CYC cycles → S_LFSRB.
  - S_LFSRB: 1 cycle; advance LFSR B; b_o ← new value → S_OPWIN.
  - S_OPWIN: displays B; op_valid_i is accepted in any cycle, including the first. op_i is latched, then → S_ALU. If OP_TIMEOUT≠0 and the window lasts OP_TIMEOUT cycles, the op ADD is latched.
  - S_ALU: 1 cycle; result_o and flags registered → S_SHOWR.
  - S_SHOWR: held DISP_CYC cycles. On the exit cycle, {op, result} is written to history → S_WAIT.
  - S_HIST: exits to S_WAIT when hist_mode_i is low.
- LFSR: Fibonacci, shift left, new = {q[W-2:0], fb}. Tap table lives in the package:
  - W=8: fb = q7^q5^q4^q3.
  - W=4: fb = q3^q2.
  - W=16: fb = q15^q13^q12^q10.
- Ops, each result zero-extended to 2W:
  - 000 AND, 001 OR, 100 XOR, 111 NOR; carry=0.
  - 010 ADD → {carry, sum}.
  - 011 SUB → {borrow, A−B mod 2^W}; carry_o = borrow.
  - 101 SHL → A << B[$clog2(W)-1:0], full 2W.
  - 110 SHR → A >> B[$clog2(W)-1:0]; carry=0.
  - zero_o = (result == 0).
- History:
  - Circular buffer; the write pointer wraps, and when full the oldest entry is overwritten.
  - hist_count_o saturates at DEPTH.
  - Entering S_HIST sets the read pointer to the newest entry.
  - hist_next_i steps to the next-older entry and wraps from oldest back to newest within the valid entries.
  - With an empty buffer: disp_val_o = 0, hist_next_i ignored.
- Ignored inputs:
  - step_i outside S_WAIT.
  - op_valid_i outside S_OPWIN.
  - hist_mode_i while busy (honoured once the block reaches S_WAIT).

## Timing
- Reset:
  - State → S_WAIT; LFSRs → seeds.
  - All outputs, history pointers and count → 0.
  - Reset takes effect mid-iteration and discards the in-flight result (no history write).
- disp_start_o pulses on the first cycle of S_SHOWA, S_OPWIN, S_SHOWR and S_HIST, and on each accepted hist_next_i.
- disp_val_o and disp_src_o are valid in the same cycle as that pulse and stay stable until the next pulse.
- Latencies:
  - step_i to A displayed: 2 cycles.
  - Op accepted to result displayed: 2 cycles.
  - One full iteration with immediate op: 2·DISP_CYC + 5 cycles.
- A history write is visible in hist_count_o on the cycle after S_SHOWR exits.

## Structure
- Package alu_seq_pkg holds:
  - the state_t enum, exported for bench probing;
  - the op_t enum;
  - the function lfsr_fb(q, W) containing the tap table;
  - the DISP_SRC_* constants.
- Sub-module lfsr_gen (parameters W, SEED; ports clk, reset, adv, q) is instantiated twice.
- The history buffer stays inline as a register array.

## Test plan
- Default parameters, reset, step → A=02, B=01; op ADD → result 0003, carry=0, zero=0; disp_start_o pulses exactly 3 times.
- Second step → A=04, B=02; op AND → result 0000, zero=1; hist_count_o=2.
- SEED_A=10, SEED_B=40, step → A=21, B=80; op SUB → result 01A1, carry=1; op SHL with A=02, B=01 → 0004.
- OP_TIMEOUT=8, no op_valid_i → ADD latched on cycle 8 of S_OPWIN; step_i and op_valid_i pulsed mid-iteration are ignored.
- DEPTH=4, run 6 iterations, then hist_mode_i=1 → hist_count_o=4; newest result is shown first, 4 hist_next_i pulses wrap back to newest; hist_mode_i=0 → S_WAIT.
- Assert reset during S_SHOWR → all outputs 0 the next cycle, hist_count_o unchanged from 0, LFSRs at seeds.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types, display-source codes and the LFSR tap table for the ALU/LFSR sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_LFSRA = 3'd1,
        S_SHOWA = 3'd2,
        S_LFSRB = 3'd3,
        S_OPWIN = 3'd4,
        S_ALU   = 3'd5,
        S_SHOWR = 3'd6,
        S_HIST  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_NOR = 3'b111
    } op_t;

    localparam logic [1:0] DISP_SRC_A    = 2'd0;
    localparam logic [1:0] DISP_SRC_B    = 2'd1;
    localparam logic [1:0] DISP_SRC_ALU  = 2'd2;
    localparam logic [1:0] DISP_SRC_HIST = 2'd3;

    // Taps are kept as masks so one function serves every supported width.
    function automatic logic lfsr_fb(input logic [15:0] q, input int w);
        logic [15:0] taps;
        case (w)
            4:       taps = 16'h000C;
            16:      taps = 16'hB400;
            default: taps = 16'h00B8;
        endcase
        lfsr_fb = ^(q & taps);
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// W-bit Fibonacci LFSR that shifts left by one each cycle adv is high.
module lfsr_gen
    import alu_seq_pkg::*;
#(
    parameter int          W    = 8,
    parameter int unsigned SEED = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] q
);

    // An all-zero state would lock up the register, so a zero seed becomes 1.
    localparam logic [W-1:0] SEED_INIT = (SEED[W-1:0] == '0) ? W'(1) : SEED[W-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            q <= SEED_INIT;
        else if (adv)
            q <= {q[W-2:0], lfsr_fb(16'(q), W)};
    end

endmodule

// File: rtl/alu_lfsr_sequencer.sv
// Step-driven sequencer: LFSR operands, op-select window, ALU, display phases and a
// browsable circular history of results.
module alu_lfsr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int          W          = 8,
    parameter int          DEPTH      = 8,
    parameter int          DISP_CYC   = 16,
    parameter int          OP_TIMEOUT = 0,
    parameter int unsigned SEED_A     = 'h01,
    parameter int unsigned SEED_B     = 'h80
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_i,
    input  logic                         op_valid_i,
    input  logic [2:0]                   op_i,
    input  logic                         hist_mode_i,
    input  logic                         hist_next_i,
    output logic                         disp_start_o,
    output logic [2*W-1:0]               disp_val_o,
    output logic [1:0]                   disp_src_o,
    output logic [W-1:0]                 a_o,
    output logic [W-1:0]                 b_o,
    output logic [2*W-1:0]               result_o,
    output logic                         carry_o,
    output logic                         zero_o,
    output logic [$clog2(DEPTH+1)-1:0]   hist_count_o,
    output logic                         busy_o
);

    localparam int W2     = 2 * W;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SH_W   = $clog2(W);
    localparam int HOLD_W = $clog2(DISP_CYC) + 1;
    localparam int WIN_W  = $clog2(OP_TIMEOUT + 1) + 1;

    typedef struct packed {
        op_t           op;
        logic [W2-1:0] res;
    } hist_entry_t;

    state_t            state;
    op_t               op_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     newest;
    logic [PW-1:0]     oldest;
    logic [PW-1:0]     next_rd;
    hist_entry_t       hist_mem [DEPTH];

    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      a_next;
    logic [W-1:0]      b_next;
    logic              adv_a;
    logic              adv_b;
    logic              hold_done;
    logic              win_timeout;
    logic              hist_we;
    logic              hist_empty;

    logic [W:0]        sum;
    logic [W:0]        diff;
    logic [W2-1:0]     alu_res;
    logic              alu_carry;

    lfsr_gen #(.W(W), .SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .adv   (adv_a),
        .q     (a_q)
    );

    lfsr_gen #(.W(W), .SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .adv   (adv_b),
        .q     (b_q)
    );

    // The operand registers capture the LFSR's next value in the same edge it advances.
    assign a_next      = {a_q[W-2:0], lfsr_fb(16'(a_q), W)};
    assign b_next      = {b_q[W-2:0], lfsr_fb(16'(b_q), W)};
    assign adv_a       = (state == S_LFSRA);
    assign adv_b       = (state == S_LFSRB);
    assign hold_done   = (hold_cnt == HOLD_W'(DISP_CYC - 1));
    assign win_timeout = (OP_TIMEOUT != 0) && (win_cnt == WIN_W'(OP_TIMEOUT - 1));
    assign hist_we     = (state == S_SHOWR) && hold_done;
    assign hist_empty  = (hist_count_o == '0);
    assign busy_o      = (state != S_WAIT) && (state != S_HIST);

    // Oldest valid slot; a full buffer has count[PW-1:0]==0, which lands on wr_ptr itself.
    assign newest  = wr_ptr - PW'(1);
    assign oldest  = wr_ptr - hist_count_o[PW-1:0];
    assign next_rd = (rd_ptr == oldest) ? newest : rd_ptr - PW'(1);

    assign sum  = {1'b0, a_o} + {1'b0, b_o};
    assign diff = {1'b0, a_o} - {1'b0, b_o};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_AND: alu_res = {{W{1'b0}}, a_o & b_o};
            OP_OR:  alu_res = {{W{1'b0}}, a_o | b_o};
            OP_XOR: alu_res = {{W{1'b0}}, a_o ^ b_o};
            OP_NOR: alu_res = {{W{1'b0}}, ~(a_o | b_o)};
            OP_ADD: begin
                alu_res   = {{(W-1){1'b0}}, sum};
                alu_carry = sum[W];
            end
            OP_SUB: begin
                alu_res   = {{(W-1){1'b0}}, diff};
                alu_carry = diff[W];
            end
            OP_SHL: alu_res = {{W{1'b0}}, a_o} << b_o[SH_W-1:0];
            OP_SHR: alu_res = {{W{1'b0}}, a_o >> b_o[SH_W-1:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_WAIT;
            op_q         <= OP_AND;
            hold_cnt     <= '0;
            win_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            hist_count_o <= '0;
            a_o          <= '0;
            b_o          <= '0;
            result_o     <= '0;
            carry_o      <= 1'b0;
            zero_o       <= 1'b0;
            disp_start_o <= 1'b0;
            disp_val_o   <= '0;
            disp_src_o   <= DISP_SRC_A;
        end else begin
            disp_start_o <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (hist_mode_i) begin
                        state        <= S_HIST;
                        rd_ptr       <= newest;
                        disp_start_o <= 1'b1;
                        disp_src_o   <= DISP_SRC_HIST;
                        disp_val_o   <= hist_empty ? '0 : hist_mem[newest].res;
                    end else if (step_i) begin
                        state <= S_LFSRA;
                    end
                end
                S_LFSRA: begin
                    a_o          <= a_next;
                    hold_cnt     <= '0;
                    state        <= S_SHOWA;
                    disp_start_o <= 1'b1;
                    disp_src_o   <= DISP_SRC_A;
                    disp_val_o   <= {{W{1'b0}}, a_next};
                end
                S_SHOWA: begin
                    if (hold_done)
                        state <= S_LFSRB;
                    else
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                S_LFSRB: begin
                    b_o          <= b_next;
                    win_cnt      <= '0;
                    state        <= S_OPWIN;
                    disp_start_o <= 1'b1;
                    disp_src_o   <= DISP_SRC_B;
                    disp_val_o   <= {{W{1'b0}}, b_next};
                end
                S_OPWIN: begin
                    if (op_valid_i) begin
                        op_q  <= op_t'(op_i);
                        state <= S_ALU;
                    end else if (win_timeout) begin
                        op_q  <= OP_ADD;
                        state <= S_ALU;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                S_ALU: begin
                    result_o     <= alu_res;
                    carry_o      <= alu_carry;
                    zero_o       <= (alu_res == '0);
                    hold_cnt     <= '0;
                    state        <= S_SHOWR;
                    disp_start_o <= 1'b1;
                    disp_src_o   <= DISP_SRC_ALU;
                    disp_val_o   <= alu_res;
                end
                S_SHOWR: begin
                    if (hold_done) begin
                        state  <= S_WAIT;
                        wr_ptr <= wr_ptr + PW'(1);
                        if (hist_count_o != CW'(DEPTH))
                            hist_count_o <= hist_count_o + CW'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_HIST: begin
                    if (!hist_mode_i) begin
                        state <= S_WAIT;
                    end else if (hist_next_i && !hist_empty) begin
                        rd_ptr       <= next_rd;
                        disp_start_o <= 1'b1;
                        disp_val_o   <= hist_mem[next_rd].res;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    // History storage carries no reset; validity is tracked by hist_count_o alone.
    always_ff @(posedge clk) begin
        if (!reset && hist_we)
            hist_mem[wr_ptr] <= {op_q, result_o};
    end

endmodule

// File: tb/tb_alu_lfsr_sequencer.sv
// Directed bench for alu_lfsr_sequencer: table-driven iterations plus hand-written
// history, op-timeout and mid-iteration reset sequences.
module tb_alu_lfsr_sequencer;
    import alu_seq_pkg::*;

    localparam int W          = 8;
    localparam int DEPTH      = 4;
    localparam int DISP_CYC   = 4;
    localparam int OP_TIMEOUT = 8;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic [2:0]  cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        op_valid;
    logic [2:0]  op_sel;
    logic [2:0]  op2_sel;
    logic        hist_mode;
    logic        hist_next;

    logic        disp_start;
    logic [15:0] disp_val;
    logic [1:0]  disp_src;
    logic [7:0]  a_val;
    logic [7:0]  b_val;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic [2:0]  hist_count;
    logic        busy;

    logic        disp_start2;
    logic [15:0] disp_val2;
    logic [1:0]  disp_src2;
    logic [7:0]  a_val2;
    logic [7:0]  b_val2;
    logic [15:0] result2;
    logic        carry2;
    logic        zero2;
    logic [3:0]  hist_count2;
    logic        busy2;

    int n_checks = 0;
    int n_fails  = 0;
    int start_cnt = 0;

    vec_t        vecs [6];
    logic [15:0] hist_exp [4];

    alu_lfsr_sequencer #(
        .W(W), .DEPTH(DEPTH), .DISP_CYC(DISP_CYC), .OP_TIMEOUT(OP_TIMEOUT),
        .SEED_A('h01), .SEED_B('h80)
    ) dut (
        .clk(clk), .reset(reset), .step_i(step), .op_valid_i(op_valid), .op_i(op_sel),
        .hist_mode_i(hist_mode), .hist_next_i(hist_next),
        .disp_start_o(disp_start), .disp_val_o(disp_val), .disp_src_o(disp_src),
        .a_o(a_val), .b_o(b_val), .result_o(result), .carry_o(carry), .zero_o(zero),
        .hist_count_o(hist_count), .busy_o(busy)
    );

    alu_lfsr_sequencer #(
        .W(W), .DEPTH(8), .DISP_CYC(DISP_CYC), .OP_TIMEOUT(0),
        .SEED_A('h10), .SEED_B('h40)
    ) dut2 (
        .clk(clk), .reset(reset), .step_i(step), .op_valid_i(op_valid), .op_i(op2_sel),
        .hist_mode_i(hist_mode), .hist_next_i(hist_next),
        .disp_start_o(disp_start2), .disp_val_o(disp_val2), .disp_src_o(disp_src2),
        .a_o(a_val2), .b_o(b_val2), .result_o(result2), .carry_o(carry2), .zero_o(zero2),
        .hist_count_o(hist_count2), .busy_o(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (disp_start)
            start_cnt <= start_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full iteration; with stop_in_showr set it returns on the first SHOWR cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] exp_a,
                                 input logic [7:0] exp_b, input logic [15:0] exp_res,
                                 input logic exp_c, input logic exp_z,
                                 input logic [2:0] exp_cnt, input bit stop_in_showr);
        int base;
        @(negedge clk);
        base = start_cnt;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        checkOutput("showA.start", 32'(disp_start), 32'd1);
        checkOutput("showA.src",   32'(disp_src),   32'(DISP_SRC_A));
        checkOutput("showA.val",   32'(disp_val),   32'(exp_a));
        checkOutput("a_o",         32'(a_val),      32'(exp_a));
        checkOutput("showA.busy",  32'(busy),       32'd1);
        repeat (DISP_CYC + 1) @(negedge clk);
        checkOutput("opwin.start", 32'(disp_start), 32'd1);
        checkOutput("opwin.src",   32'(disp_src),   32'(DISP_SRC_B));
        checkOutput("opwin.val",   32'(disp_val),   32'(exp_b));
        checkOutput("b_o",         32'(b_val),      32'(exp_b));
        op_valid = 1'b1;
        op_sel   = op;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        checkOutput("showR.start", 32'(disp_start), 32'd1);
        checkOutput("showR.src",   32'(disp_src),   32'(DISP_SRC_ALU));
        checkOutput("showR.val",   32'(disp_val),   32'(exp_res));
        checkOutput("result_o",    32'(result),     32'(exp_res));
        checkOutput("carry_o",     32'(carry),      32'(exp_c));
        checkOutput("zero_o",      32'(zero),       32'(exp_z));
        if (!stop_in_showr) begin
            repeat (DISP_CYC) @(negedge clk);
            checkOutput("iter.busy_done",   32'(busy),              32'd0);
            checkOutput("iter.hist_count",  32'(hist_count),        32'(exp_cnt));
            checkOutput("iter.start_pulses", 32'(start_cnt - base), 32'd3);
        end
    endtask

    initial begin
        vecs[0] = '{op: 3'b010, a: 8'h02, b: 8'h01, res: 16'h0003, c: 1'b0, z: 1'b0, cnt: 3'd1};
        vecs[1] = '{op: 3'b000, a: 8'h04, b: 8'h02, res: 16'h0000, c: 1'b0, z: 1'b1, cnt: 3'd2};
        vecs[2] = '{op: 3'b011, a: 8'h08, b: 8'h04, res: 16'h0004, c: 1'b0, z: 1'b0, cnt: 3'd3};
        vecs[3] = '{op: 3'b100, a: 8'h11, b: 8'h08, res: 16'h0019, c: 1'b0, z: 1'b0, cnt: 3'd4};
        vecs[4] = '{op: 3'b111, a: 8'h23, b: 8'h11, res: 16'h00CC, c: 1'b0, z: 1'b0, cnt: 3'd4};
        vecs[5] = '{op: 3'b110, a: 8'h47, b: 8'h23, res: 16'h0008, c: 1'b0, z: 1'b0, cnt: 3'd4};
        hist_exp[0] = 16'h00CC;
        hist_exp[1] = 16'h0019;
        hist_exp[2] = 16'h0004;
        hist_exp[3] = 16'h0008;

        reset     = 1'b1;
        step      = 1'b0;
        op_valid  = 1'b0;
        op_sel    = 3'b000;
        op2_sel   = 3'b011;
        hist_mode = 1'b0;
        hist_next = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst.a_o",        32'(a_val),      32'd0);
        checkOutput("rst.result_o",   32'(result),     32'd0);
        checkOutput("rst.disp_val",   32'(disp_val),   32'd0);
        checkOutput("rst.hist_count", 32'(hist_count), 32'd0);
        checkOutput("rst.busy",       32'(busy),       32'd0);
        checkOutput("rst.lfsr_a",     32'(dut.u_lfsr_a.q), 32'h01);
        checkOutput("rst.lfsr_b",     32'(dut.u_lfsr_b.q), 32'h80);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                          vecs[i].c, vecs[i].z, vecs[i].cnt, 1'b0);
            if (i == 0) begin
                checkOutput("seed2.a_o",      32'(a_val2),      32'h21);
                checkOutput("seed2.b_o",      32'(b_val2),      32'h80);
                checkOutput("seed2.result_o", 32'(result2),     32'h01A1);
                checkOutput("seed2.carry_o",  32'(carry2),      32'd1);
                checkOutput("seed2.zero_o",   32'(zero2),       32'd0);
                checkOutput("seed2.count",    32'(hist_count2), 32'd1);
            end
        end

        // History browse; hist_mode beats a simultaneous step.
        @(negedge clk);
        hist_mode = 1'b1;
        step      = 1'b1;
        @(negedge clk);
        step = 1'b0;
        checkOutput("hist.start", 32'(disp_start), 32'd1);
        checkOutput("hist.src",   32'(disp_src),   32'(DISP_SRC_HIST));
        checkOutput("hist.newest", 32'(disp_val),  32'h0008);
        checkOutput("hist.busy",  32'(busy),       32'd0);
        checkOutput("hist.count", 32'(hist_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            hist_next = 1'b1;
            @(negedge clk);
            hist_next = 1'b0;
            checkOutput("hist.next_start", 32'(disp_start), 32'd1);
            checkOutput("hist.next_val",   32'(disp_val),   32'(hist_exp[k]));
        end
        @(negedge clk);
        checkOutput("hist.idle_start", 32'(disp_start), 32'd0);
        checkOutput("hist.idle_val",   32'(disp_val),   32'h0008);
        hist_mode = 1'b0;
        @(negedge clk);
        checkOutput("hist.exit_state", 32'(dut.state), 32'(S_WAIT));

        // Op window timeout with stray step/op_valid pulses during SHOWA.
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        checkOutput("to.a_o", 32'(a_val), 32'h8E);
        step     = 1'b1;
        op_valid = 1'b1;
        op_sel   = 3'b111;
        @(negedge clk);
        step     = 1'b0;
        op_valid = 1'b0;
        repeat (DISP_CYC) @(negedge clk);
        checkOutput("to.opwin_start", 32'(disp_start), 32'd1);
        checkOutput("to.b_o",         32'(b_val),      32'h47);
        repeat (7) @(negedge clk);
        checkOutput("to.cycle8_state", 32'(dut.state), 32'(S_OPWIN));
        @(negedge clk);
        checkOutput("to.alu_state", 32'(dut.state), 32'(S_ALU));
        @(negedge clk);
        checkOutput("to.showR_start", 32'(disp_start), 32'd1);
        checkOutput("to.result_o",    32'(result),     32'h00D5);
        checkOutput("to.carry_o",     32'(carry),      32'd0);
        repeat (DISP_CYC) @(negedge clk);
        checkOutput("to.busy_done",  32'(busy),       32'd0);
        checkOutput("to.hist_count", 32'(hist_count), 32'd4);
        @(negedge clk);
        checkOutput("to.no_restart", 32'(busy), 32'd0);

        // Empty history after reset, then reset during SHOWR discards the result.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst2.hist_count", 32'(hist_count), 32'd0);
        hist_mode = 1'b1;
        @(negedge clk);
        checkOutput("empty.start", 32'(disp_start), 32'd1);
        checkOutput("empty.src",   32'(disp_src),   32'(DISP_SRC_HIST));
        checkOutput("empty.val",   32'(disp_val),   32'd0);
        hist_next = 1'b1;
        @(negedge clk);
        hist_next = 1'b0;
        checkOutput("empty.next_ignored", 32'(disp_start), 32'd0);
        hist_mode = 1'b0;
        @(negedge clk);
        checkOutput("empty.exit_state", 32'(dut.state), 32'(S_WAIT));

        applyStimulus(3'b101, 8'h02, 8'h01, 16'h0004, 1'b0, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst.a_o",        32'(a_val),      32'd0);
        checkOutput("midrst.b_o",        32'(b_val),      32'd0);
        checkOutput("midrst.result_o",   32'(result),     32'd0);
        checkOutput("midrst.disp_start", 32'(disp_start), 32'd0);
        checkOutput("midrst.disp_val",   32'(disp_val),   32'd0);
        checkOutput("midrst.disp_src",   32'(disp_src),   32'd0);
        checkOutput("midrst.busy",       32'(busy),       32'd0);
        checkOutput("midrst.hist_count", 32'(hist_count), 32'd0);
        checkOutput("midrst.lfsr_a",     32'(dut.u_lfsr_a.q), 32'h01);
        checkOutput("midrst.lfsr_b",     32'(dut.u_lfsr_b.q), 32'h80);
        reset = 1'b0;
        applyStimulus(3'b010, 8'h02, 8'h01, 16'h0003, 1'b0, 1'b0, 3'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
